// File: rtl/shake256_squeeze_pkg.sv
// Shared Keccak types and helpers for the SHAKE256 squeeze stage.
package shake256_squeeze_pkg;

    localparam int LANE_W         = 64;
    localparam int RATE_LANES_256 = 17;

    // Bit A[x][y][z]; lane (x,y) is state[x][y], bit z ascending.
    typedef logic [0:4][0:4][0:LANE_W-1] state_t;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} sq_state_e;

    // Rate lane i sits at x = i mod 5, y = i div 5.
    function automatic int lane_x(input int i);
        return i % 5;
    endfunction

    function automatic int lane_y(input int i);
        return i / 5;
    endfunction

endpackage

// File: rtl/shake256_squeeze_if.sv
// XOF output stream: 64-bit words over valid/ready.
interface shake256_squeeze_if;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/shake256_squeeze_keccak_rate_extract.sv
// Combinational pick of the rate lanes out of a Keccak state.
// Lane word bit z is A[x][y][z], so the packed [0:63] lane is bit-reversed
// into a conventional [63:0] word.
module keccak_rate_extract
    import shake256_squeeze_pkg::*;
#(
    parameter int RATE_LANES = RATE_LANES_256
) (
    input  state_t                              state_in,
    output logic [RATE_LANES-1:0][LANE_W-1:0]   lanes
);

    for (genvar i = 0; i < RATE_LANES; i++) begin : g_lane
        localparam int X = lane_x(i);
        localparam int Y = lane_y(i);
        for (genvar z = 0; z < LANE_W; z++) begin : g_bit
            assign lanes[i][z] = state_in[X][Y][z];
        end
    end

endmodule

// File: rtl/shake256_squeeze.sv
// SHAKE256 squeeze: buffers one rate block of a permuted state and streams
// its lanes out, asking for another permutation when a block runs dry.
module shake256_squeeze
    import shake256_squeeze_pkg::*;
#(
    parameter int RATE_LANES = RATE_LANES_256,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     out_words,
    input  state_t               state_in,
    input  logic                 state_valid,
    output logic                 state_ready,
    output logic                 perm_req,
    output logic                 busy,
    output logic                 done,
    shake256_squeeze_if.master   xof
);

    localparam int IDX_W = $clog2(RATE_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    logic [RATE_LANES-1:0][LANE_W-1:0] lanes;
    logic [RATE_LANES-1:0][LANE_W-1:0] lane_buf;
    sq_state_e                         st;
    logic [IDX_W-1:0]                  idx;
    logic [CNT_W-1:0]                  rem;
    logic                              xfer;

    keccak_rate_extract #(.RATE_LANES(RATE_LANES)) u_extract (
        .state_in (state_in),
        .lanes    (lanes)
    );

    assign xfer = xof.out_valid & xof.out_ready;

    // Squeeze FSM with registered handshake outputs; out_data is loaded one
    // word ahead so a held word never changes under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            idx           <= '0;
            rem           <= '0;
            lane_buf      <= '0;
            state_ready   <= 1'b0;
            perm_req      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            xof.out_data  <= '0;
            xof.out_valid <= 1'b0;
        end else begin
            perm_req <= 1'b0;
            done     <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        rem  <= out_words;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (out_words == '0) begin
                            st   <= FIN;
                            done <= 1'b1;
                        end else begin
                            st          <= LOAD;
                            state_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (state_valid && state_ready) begin
                        lane_buf      <= lanes;
                        idx           <= '0;
                        xof.out_data  <= lanes[0];
                        xof.out_valid <= 1'b1;
                        state_ready   <= 1'b0;
                        st            <= EMIT;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        rem <= rem - 1'b1;
                        if (rem == CNT_W'(1)) begin
                            xof.out_valid <= 1'b0;
                            done          <= 1'b1;
                            st            <= FIN;
                        end else if (idx == LAST_IDX) begin
                            // Block exhausted: permutation runs on the held state.
                            xof.out_valid <= 1'b0;
                            perm_req      <= 1'b1;
                            state_ready   <= 1'b1;
                            st            <= LOAD;
                        end else begin
                            idx          <= idx + 1'b1;
                            xof.out_data <= lane_buf[idx + 1'b1];
                        end
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
